if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage ARM pipeline, directly upstream of the ID stage.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage_fetch_queue.sv | 67 ++++++
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (idle, request in flight, request being dropped)
//   fetch_entry_t : one fetch-queue entry, {PC+4, instruction word}
//   next_pc       : sequential fetch address, wraps modulo 2^32
package if_stage_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrop
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_fetch_queue.sv
// Small FIFO holding fetched words until the IF/ID register can take them.
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_data   : enqueue one entry
//   pop               : drop the head entry
//   clear             : empty the queue; dominates push
//   head              : entry at the head (meaningful when !empty)
//   count, empty, full: occupancy
module if_stage_fetch_queue
    import if_stage_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  fetch_entry_t              push_data,
    output fetch_entry_t              head,
    output logic [$clog2(QDEPTH):0]   count,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(QDEPTH);

    fetch_entry_t    mem [QDEPTH];
    logic [PtrW-1:0] rptr;
    logic [PtrW-1:0] wptr;
    logic            push_ok;
    logic            pop_ok;

    always_comb begin
        empty   = (count == '0);
        full    = (count == FullCount);
        // A push into a full queue is only legal when the head leaves in the same cycle.
        push_ok = push && (!full || pop);
        pop_ok  = pop && !empty;
        head    = mem[rptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding request at a time to
// instruction memory, buffers returned words and drives the IF/ID register.
//   clk, rst             : clock, asynchronous active-low reset
//   freeze               : hold the IF/ID register (hazard from ID)
//   branch_taken         : flush and redirect fetch to branch_addr
//   branch_addr          : redirect target
//   imem_req, imem_addr  : level request and its address, held until imem_ack
//   imem_ack, imem_rdata : request completion and fetched word (same cycle)
//   PC, instruction      : IF/ID register, PC is fetch address + 4
//   valid                : IF/ID register holds a real instruction
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned QDEPTH    = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);

    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic          accept;
    logic          advance;
    logic          q_push;
    logic          q_pop;
    logic          q_empty;
    logic          q_full;
    logic [CntW-1:0] q_count;
    logic [CntW:0] count_after;
    fetch_entry_t  q_head;
    fetch_entry_t  fetched;

    assign imem_req  = (state != StIdle);
    assign imem_addr = req_addr;

    always_comb begin
        accept  = (state == StFetch) && imem_ack && !branch_taken;
        advance = !branch_taken && !freeze;
        fetched = '{pc: next_pc(fetch_pc), instr: imem_rdata};
        q_pop   = advance && !q_empty;
        // With an empty queue and a free output register the word bypasses the queue.
        q_push  = accept && !(advance && q_empty);
        count_after = {1'b0, q_count} + (CntW + 1)'(q_push) - (CntW + 1)'(q_pop);
    end

    if_stage_fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .pop      (q_pop),
        .clear    (branch_taken),
        .push_data(fetched),
        .head     (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            fetch_pc    <= RESET_PC;
            req_addr    <= RESET_PC;
            PC          <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else begin
            // Fetch control
            if (branch_taken) begin
                fetch_pc <= branch_addr;
                if (state == StDrop) begin
                    // The stale request may finish this very cycle; then go straight on.
                    if (imem_ack) begin
                        state    <= StFetch;
                        req_addr <= branch_addr;
                    end
                end else if (state == StFetch && !imem_ack) begin
                    // Keep the in-flight request alive, throw its data away later.
                    state <= StDrop;
                end else begin
                    state    <= StFetch;
                    req_addr <= branch_addr;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        if (!q_full) begin
                            state    <= StFetch;
                            req_addr <= fetch_pc;
                        end
                    end
                    StFetch: begin
                        if (imem_ack) begin
                            fetch_pc <= fetched.pc;
                            // Only re-issue if the next word is guaranteed a slot.
                            if (count_after < (CntW + 1)'(QDEPTH)) begin
                                req_addr <= fetched.pc;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end
                    StDrop: begin
                        if (imem_ack) begin
                            state    <= StFetch;
                            req_addr <= fetch_pc;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end

            // IF/ID register
            if (branch_taken) begin
                valid       <= 1'b0;
                instruction <= NOP_INSTR;
                PC          <= '0;
            end else if (!freeze) begin
                if (!q_empty) begin
                    PC          <= q_head.pc;
                    instruction <= q_head.instr;
                    valid       <= 1'b1;
                end else if (accept) begin
                    PC          <= fetched.pc;
                    instruction <= fetched.instr;
                    valid       <= 1'b1;
                end else begin
                    valid       <= 1'b0;
                    instruction <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed stimulus, expected IF/ID stream kept in a scoreboard queue
// and checked by an independent monitor, plus point checks of request/flush timing.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid;
    int          lat;
    int          wait_cnt;

    logic        req2;
    logic [31:0] addr2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        valid2;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_held;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC          (pc_out),
        .instruction (instr_out),
        .valid       (valid)
    );

    // Second instance: wrap-around reset PC, zero-wait memory, distinct NOP.
    if_stage #(
        .RESET_PC (32'hFFFF_FFF8),
        .QDEPTH   (2),
        .NOP_INSTR(32'hE1A0_0000)
    ) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .freeze      (1'b0),
        .branch_taken(1'b0),
        .branch_addr (32'h0),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ack    (req2),
        .imem_rdata  (addr2),
        .PC          (pc2),
        .instruction (instr2),
        .valid       (valid2)
    );

    // Memory: word equals its address, ack after `lat` wait cycles.
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req) wait_cnt <= wait_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
        exp_q.push_back('{pc: p, instr: i});
    endtask

    // Monitor: every fresh valid output (edge not frozen) must be the next expected entry.
    initial begin
        forever begin
            @(posedge clk);
            mon_held = freeze && !branch_taken;
            @(negedge clk);
            if (rst && valid && !mon_held) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream: unexpected PC=%h instr=%h with nothing expected",
                             pc_out, instr_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pc_out !== mon_e.pc || instr_out !== mon_e.instr) begin
                        bad++;
                        $display("FAIL stream: got PC=%h instr=%h want PC=%h instr=%h",
                                 pc_out, instr_out, mon_e.pc, mon_e.instr);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        rst2 = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = 32'h0;
        lat = 0;
        step(2);

        // Reset state of both instances
        chk("rst valid", {31'b0, valid}, 32'h0);
        chk("rst PC", pc_out, 32'h0);
        chk("rst instr", instr_out, 32'h0);
        chk("rst req", {31'b0, imem_req}, 32'h0);
        chk("rst addr", imem_addr, 32'h0);
        chk("rst2 valid", {31'b0, valid2}, 32'h0);
        chk("rst2 instr", instr2, 32'hE1A0_0000);
        chk("rst2 addr", addr2, 32'hFFFF_FFF8);

        // Zero-wait streaming, then a freeze that fills the queue
        push_exp(32'd4, 32'd0);
        push_exp(32'd8, 32'd4);
        push_exp(32'd12, 32'd8);
        push_exp(32'd16, 32'd12);
        push_exp(32'd20, 32'd16);
        push_exp(32'd24, 32'd20);
        rst = 1'b1;
        step(1);
        chk("e1 valid", {31'b0, valid}, 32'h0);
        chk("e1 req", {31'b0, imem_req}, 32'h1);
        chk("e1 addr", imem_addr, 32'h0);
        step(1);
        chk("e2 PC", pc_out, 32'd4);
        chk("e2 valid", {31'b0, valid}, 32'h1);
        step(1);
        chk("e3 PC", pc_out, 32'd8);
        step(1);
        chk("e4 PC", pc_out, 32'd12);
        freeze = 1'b1;
        step(1);
        chk("frz1 PC", pc_out, 32'd12);
        step(1);
        chk("frz2 req dropped", {31'b0, imem_req}, 32'h0);
        step(1);
        chk("frz3 PC", pc_out, 32'd12);
        chk("frz3 valid", {31'b0, valid}, 32'h1);
        chk("frz3 req", {31'b0, imem_req}, 32'h0);
        freeze = 1'b0;
        step(1);
        chk("unfrz PC a", pc_out, 32'd16);
        step(1);
        chk("unfrz PC b", pc_out, 32'd20);
        step(1);
        chk("unfrz PC c", pc_out, 32'd24);

        // Branch with same-cycle ack
        push_exp(32'h104, 32'h100);
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        step(1);
        branch_taken = 1'b0;
        chk("br valid", {31'b0, valid}, 32'h0);
        chk("br PC", pc_out, 32'h0);
        chk("br instr", instr_out, 32'h0);
        chk("br addr", imem_addr, 32'h100);
        step(1);
        chk("br target PC", pc_out, 32'h104);
        chk("br target instr", instr_out, 32'h100);

        // Branch while a slow request is pending
        push_exp(32'h204, 32'h200);
        lat = 3;
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        step(1);
        branch_taken = 1'b0;
        chk("drop valid", {31'b0, valid}, 32'h0);
        chk("drop addr held", imem_addr, 32'h104);
        chk("drop req", {31'b0, imem_req}, 32'h1);
        step(2);
        chk("drop addr still", imem_addr, 32'h104);
        step(1);
        chk("drop refetch addr", imem_addr, 32'h200);
        chk("drop no stale", {31'b0, valid}, 32'h0);
        lat = 0;
        step(1);
        chk("drop target PC", pc_out, 32'h204);

        // Branch and freeze together
        push_exp(32'h304, 32'h300);
        push_exp(32'h308, 32'h304);
        push_exp(32'h30C, 32'h308);
        branch_taken = 1'b1;
        branch_addr = 32'h300;
        freeze = 1'b1;
        step(1);
        branch_taken = 1'b0;
        freeze = 1'b0;
        chk("brfrz valid", {31'b0, valid}, 32'h0);
        chk("brfrz PC", pc_out, 32'h0);
        chk("brfrz addr", imem_addr, 32'h300);
        step(1);
        chk("brfrz PC a", pc_out, 32'h304);
        step(2);
        chk("brfrz PC c", pc_out, 32'h30C);
        freeze = 1'b1;
        step(1);
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

        // Wrap-around reset PC and asynchronous reset mid-fetch
        rst2 = 1'b1;
        step(1);
        chk("w e1 req", {31'b0, req2}, 32'h1);
        chk("w e1 valid", {31'b0, valid2}, 32'h0);
        step(1);
        chk("w e2 PC", pc2, 32'hFFFF_FFFC);
        chk("w e2 instr", instr2, 32'hFFFF_FFF8);
        chk("w e2 valid", {31'b0, valid2}, 32'h1);
        step(1);
        chk("w e3 PC", pc2, 32'h0);
        chk("w e3 instr", instr2, 32'hFFFF_FFFC);
        step(1);
        chk("w e4 PC", pc2, 32'h4);
        rst2 = 1'b0;
        #1;
        chk("async rst valid", {31'b0, valid2}, 32'h0);
        chk("async rst PC", pc2, 32'h0);
        chk("async rst instr", instr2, 32'hE1A0_0000);
        chk("async rst req", {31'b0, req2}, 32'h0);
        chk("async rst addr", addr2, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
